fcp6_top: RTL and testbench
===========================

FCP6_TOP -- requirements
Module: fcp6_top

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h33, the embedded slave's 7-bit address.
REQ-002 SHALL have parameter SLAVE_RD_INIT, default 8'h58, the reset value of the slave read register.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8, the number of cycles the master waits for a response.
REQ-004 clk  in  1  single clock; all logic updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request; sampled only while the master is IDLE.
REQ-007 header_in  in  8  transaction header: [7:1] target address, [0] direction (1 = write, 0 = read).
REQ-008 data_in  in  8  write payload.
REQ-009 data  out  2  FCP6 data lane, as driven by whichever agent currently owns it.
REQ-010 ctrl  out  2  FCP6 control lane, driven by the master: 00 IDLE, 01 HEADER, 10 DATA, 11 TURNAROUND.
REQ-011 ack  out  1  slave acknowledge, a one-cycle pulse.
REQ-012 busy  out  1  master transaction in progress.
REQ-013 read_data  out  8  last byte the master received in a read.
REQ-014 slave_rx_data  out  8  last byte the slave accepted in a write.
REQ-015 done  out  1  one-cycle end-of-transaction pulse.
REQ-016 error  out  1  one-cycle pulse, coincident with done, when the transaction failed.

Function
REQ-017 The block SHALL contain one master and one slave connected only through data, ctrl and ack.
REQ-018 Bytes SHALL be sent in 4 two-bit beats, MSB first: beat k carries bits [7-2k:6-2k].
REQ-019 Master states SHALL be IDLE, HDR, WDATA, PAR, WAIT_ACK, TURN, RDATA, FIN.
REQ-020 Start in IDLE SHALL latch header_in and data_in, set busy and enter HDR on the same edge.
REQ-021 HDR SHALL drive ctrl=01 for 4 cycles; the next state SHALL be WDATA if bit0=1, otherwise TURN.
REQ-022 WDATA SHALL drive ctrl=10 with 4 payload beats, then go to PAR (if enabled) or WAIT_ACK.
REQ-023 The slave SHALL shift in the header, then compare [7:1] to SLAVE_ADDR.
REQ-024 On a write with an address match, the slave SHALL load slave_rx_data and pulse ack on the first WAIT_ACK cycle.
REQ-025 Writes SHALL NOT modify the slave read register.
REQ-026 WAIT_ACK SHALL go to FIN on ack; with no ack within ACK_TIMEOUT cycles it SHALL go to FIN with error.
REQ-027 TURN SHALL drive ctrl=11 for 1 cycle.
REQ-028 On an address match in TURN, the slave SHALL pulse ack and then drive its read register in 4 beats while the master drives ctrl=10 (RDATA).
REQ-029 On a read with no ack in TURN, the master SHALL wait up to ACK_TIMEOUT cycles and then go to FIN with error; read_data SHALL remain unchanged.
REQ-030 After the 4th RDATA beat the master SHALL update read_data and go to FIN.
REQ-031 FIN SHALL pulse done (plus error if set), clear busy and return to IDLE.
REQ-032 A successful write SHALL finish within 10 cycles of start, or 11 cycles with parity enabled.
REQ-033 A successful read SHALL finish within 11 cycles of start.
REQ-034 Start while busy SHALL be ignored.
REQ-035 With an address mismatch the slave SHALL stay silent: no ack, and no register change.
REQ-036 Whenever no agent owns the lanes, data and ctrl SHALL be 00.

Reset
REQ-037 While rst=0, regardless of clk: both FSMs SHALL be IDLE, data/ctrl/ack/busy/done/error = 0, read_data = 0, slave_rx_data = 0, and the slave read register = SLAVE_RD_INIT.
REQ-038 A reset mid-transaction SHALL abort it with no done pulse; after release the block SHALL accept a new start.

Configuration
REQ-039 With FCP6_PARITY_EN defined, the master SHALL send one PAR beat after WDATA (ctrl=10), carrying on data[0] the even parity of header and payload, with data[1]=0.
REQ-040 With FCP6_PARITY_EN defined and a parity mismatch, the slave SHALL withhold ack and leave slave_rx_data unchanged, so the master times out with error.
REQ-041 Without FCP6_PARITY_EN, the PAR state SHALL be skipped and no parity logic SHALL exist.

Verification
REQ-042 Write: header 8'b01100111, data 8'hA5, start pulse -> slave_rx_data=8'hA5, exactly one ack, done with error=0 within 20 cycles.
REQ-043 Read after that write: header 8'b01100110 -> read_data=8'h58, slave_rx_data still 8'hA5, error=0.
REQ-044 Write to address 7'h01, data 8'h3C -> no ack, done with error=1 after the timeout, slave_rx_data unchanged.
REQ-045 Start pulse during a busy write -> ignored; only one done pulse.
REQ-046 rst=0 at cycle 3 of a write -> all outputs 0 at once and slave_rx_data=0; a new write of 8'h11 then succeeds.
REQ-047 With FCP6_PARITY_EN, a forced parity-beat flip -> error=1 and slave_rx_data unchanged.

Source files
------------

// File: rtl/fcp6_top.sv
// fcp6_top: FCP6 link with one master and one embedded slave. The two agents
// talk only through the shared data/ctrl lanes and the ack line. Bytes move as
// four 2-bit beats, MSB first.
// Optional feature: define FCP6_PARITY_EN to add a write parity beat after the
// payload. The slave withholds ack when that beat does not match.
module fcp6_top #(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h33,
    parameter logic [7:0]  SLAVE_RD_INIT = 8'h58,
    parameter int unsigned ACK_TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] header_in,
    input  logic [7:0] data_in,
    output logic [1:0] data,
    output logic [1:0] ctrl,
    output logic       ack,
    output logic       busy,
    output logic [7:0] read_data,
    output logic [7:0] slave_rx_data,
    output logic       done,
    output logic       error
);

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HDR  = 2'b01;
    localparam logic [1:0] CTRL_DATA = 2'b10;
    localparam logic [1:0] CTRL_TURN = 2'b11;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        M_IDLE, M_HDR, M_WDATA, M_PAR, M_WAIT_ACK, M_TURN, M_RDATA, M_FIN
    } mst_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WDATA, S_PAR, S_TURN, S_RDATA
    } slv_t;

    // Beat k of a byte, MSB first.
    function automatic logic [1:0] f_beat(input logic [7:0] b, input logic [1:0] k);
        logic [1:0] v;
        case (k)
            2'd0:    v = b[7:6];
            2'd1:    v = b[5:4];
            2'd2:    v = b[3:2];
            default: v = b[1:0];
        endcase
        return v;
    endfunction

    // Master registers
    mst_t          r_mst;
    logic [7:0]    r_hdr;
    logic [7:0]    r_pay;
    logic [2:0]    r_beat;
    logic [TW-1:0] r_wait;
    logic [5:0]    r_rx_shift;
    logic [1:0]    r_ctrl;
    logic [1:0]    r_m_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [7:0]    r_read_data;

    // Slave registers
    slv_t          r_slv;
    logic [5:0]    r_s_shift;
    logic [2:0]    r_s_cnt;
    logic [1:0]    r_s_data;
    logic          r_ack;
    logic [7:0]    r_rx_data;
    logic [7:0]    r_s_rdreg;
`ifdef FCP6_PARITY_EN
    logic [7:0]    r_s_hdr;
    logic [7:0]    r_s_byte;
`endif

    // Shared lanes: an idle agent drives zeros, so OR-ing gives the owner's value.
    logic [1:0] w_data;
    logic [1:0] w_ctrl;
    logic       w_ack;
    logic [7:0] w_s_word;
    logic       w_s_match;

    assign w_data    = r_m_data | r_s_data;
    assign w_ctrl    = r_ctrl;
    assign w_ack     = r_ack;
    assign w_s_word  = {r_s_shift, w_data};
    assign w_s_match = (w_s_word[7:1] == SLAVE_ADDR);

    assign data          = w_data;
    assign ctrl          = w_ctrl;
    assign ack           = w_ack;
    assign busy          = r_busy;
    assign read_data     = r_read_data;
    assign slave_rx_data = r_rx_data;
    assign done          = r_done;
    assign error         = r_error;

    // Master FSM: lane outputs are registered and set up for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mst       <= M_IDLE;
            r_hdr       <= '0;
            r_pay       <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_rx_shift  <= '0;
            r_ctrl      <= CTRL_IDLE;
            r_m_data    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_mst)
                M_IDLE: begin
                    if (start) begin
                        r_hdr    <= header_in;
                        r_pay    <= data_in;
                        r_busy   <= 1'b1;
                        r_mst    <= M_HDR;
                        r_ctrl   <= CTRL_HDR;
                        r_m_data <= header_in[7:6];
                        r_beat   <= 3'd1;
                    end
                end
                M_HDR: begin
                    if (r_beat == 3'd4) begin
                        if (r_hdr[0]) begin
                            r_mst    <= M_WDATA;
                            r_ctrl   <= CTRL_DATA;
                            r_m_data <= f_beat(r_pay, 2'd0);
                            r_beat   <= 3'd1;
                        end else begin
                            r_mst    <= M_TURN;
                            r_ctrl   <= CTRL_TURN;
                            r_m_data <= '0;
                        end
                    end else begin
                        r_m_data <= f_beat(r_hdr, r_beat[1:0]);
                        r_beat   <= r_beat + 3'd1;
                    end
                end
                M_WDATA: begin
                    if (r_beat == 3'd4) begin
`ifdef FCP6_PARITY_EN
                        r_mst    <= M_PAR;
                        r_m_data <= {1'b0, ^{r_hdr, r_pay}};
`else
                        r_mst    <= M_WAIT_ACK;
                        r_ctrl   <= CTRL_IDLE;
                        r_m_data <= '0;
                        r_wait   <= '0;
`endif
                    end else begin
                        r_m_data <= f_beat(r_pay, r_beat[1:0]);
                        r_beat   <= r_beat + 3'd1;
                    end
                end
                M_PAR: begin
                    r_mst    <= M_WAIT_ACK;
                    r_ctrl   <= CTRL_IDLE;
                    r_m_data <= '0;
                    r_wait   <= '0;
                end
                M_WAIT_ACK: begin
                    if (w_ack) begin
                        if (r_hdr[0]) begin
                            r_mst  <= M_FIN;
                            r_done <= 1'b1;
                        end else begin
                            r_mst  <= M_RDATA;
                            r_ctrl <= CTRL_DATA;
                            r_beat <= '0;
                        end
                    end else if (r_wait == TW'(ACK_TIMEOUT - 1)) begin
                        r_mst   <= M_FIN;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                M_TURN: begin
                    r_m_data <= '0;
                    if (w_ack) begin
                        r_mst  <= M_RDATA;
                        r_ctrl <= CTRL_DATA;
                        r_beat <= '0;
                    end else begin
                        r_mst  <= M_WAIT_ACK;
                        r_ctrl <= CTRL_IDLE;
                        r_wait <= '0;
                    end
                end
                M_RDATA: begin
                    r_rx_shift <= {r_rx_shift[3:0], w_data};
                    if (r_beat == 3'd3) begin
                        r_read_data <= {r_rx_shift, w_data};
                        r_mst       <= M_FIN;
                        r_done      <= 1'b1;
                        r_ctrl      <= CTRL_IDLE;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                M_FIN: begin
                    r_busy <= 1'b0;
                    r_mst  <= M_IDLE;
                end
                default: r_mst <= M_IDLE;
            endcase
        end
    end

    // Slave FSM: samples the lanes each edge, acks matches and drives read beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slv     <= S_IDLE;
            r_s_shift <= '0;
            r_s_cnt   <= '0;
            r_s_data  <= '0;
            r_ack     <= 1'b0;
            r_rx_data <= '0;
            r_s_rdreg <= SLAVE_RD_INIT;
`ifdef FCP6_PARITY_EN
            r_s_hdr   <= '0;
            r_s_byte  <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_slv)
                S_IDLE: begin
                    if (w_ctrl == CTRL_HDR) begin
                        r_s_shift <= {r_s_shift[3:0], w_data};
                        r_s_cnt   <= 3'd1;
                        r_slv     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_ctrl != CTRL_HDR) begin
                        r_slv <= S_IDLE;
                    end else if (r_s_cnt == 3'd3) begin
`ifdef FCP6_PARITY_EN
                        r_s_hdr <= w_s_word;
`endif
                        if (!w_s_match) begin
                            r_slv <= S_IDLE;
                        end else if (w_s_word[0]) begin
                            r_slv   <= S_WDATA;
                            r_s_cnt <= '0;
                        end else begin
                            r_ack <= 1'b1;
                            r_slv <= S_TURN;
                        end
                    end else begin
                        r_s_shift <= {r_s_shift[3:0], w_data};
                        r_s_cnt   <= r_s_cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (w_ctrl != CTRL_DATA) begin
                        r_slv <= S_IDLE;
                    end else if (r_s_cnt == 3'd3) begin
`ifdef FCP6_PARITY_EN
                        r_s_byte <= w_s_word;
                        r_slv    <= S_PAR;
`else
                        r_rx_data <= w_s_word;
                        r_ack     <= 1'b1;
                        r_slv     <= S_IDLE;
`endif
                    end else begin
                        r_s_shift <= {r_s_shift[3:0], w_data};
                        r_s_cnt   <= r_s_cnt + 3'd1;
                    end
                end
`ifdef FCP6_PARITY_EN
                S_PAR: begin
                    if (w_ctrl == CTRL_DATA && !w_data[1] &&
                        w_data[0] == ^{r_s_hdr, r_s_byte}) begin
                        r_rx_data <= r_s_byte;
                        r_ack     <= 1'b1;
                    end
                    r_slv <= S_IDLE;
                end
`endif
                S_TURN: begin
                    if (w_ctrl == CTRL_TURN) begin
                        r_s_data <= f_beat(r_s_rdreg, 2'd0);
                        r_s_cnt  <= 3'd1;
                        r_slv    <= S_RDATA;
                    end else begin
                        r_slv <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (r_s_cnt == 3'd4) begin
                        r_s_data <= '0;
                        r_slv    <= S_IDLE;
                    end else begin
                        r_s_data <= f_beat(r_s_rdreg, r_s_cnt[1:0]);
                        r_s_cnt  <= r_s_cnt + 3'd1;
                    end
                end
                default: r_slv <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcp6_top.sv
// tb_fcp6_top: directed transactions with a done-triggered scoreboard for fcp6_top.
module tb_fcp6_top;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] header_in;
    logic [7:0] data_in;
    logic [1:0] data;
    logic [1:0] ctrl;
    logic       ack;
    logic       busy;
    logic [7:0] read_data;
    logic [7:0] slave_rx_data;
    logic       done;
    logic       error;

    fcp6_top #(
        .SLAVE_ADDR   (7'h33),
        .SLAVE_RD_INIT(8'h58),
        .ACK_TIMEOUT  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .header_in    (header_in),
        .data_in      (data_in),
        .data         (data),
        .ctrl         (ctrl),
        .ack          (ack),
        .busy         (busy),
        .read_data    (read_data),
        .slave_rx_data(slave_rx_data),
        .done         (done),
        .error        (error)
    );

`ifdef FCP6_PARITY_EN
    localparam int unsigned WLAT = 11;
`else
    localparam int unsigned WLAT = 10;
`endif

    typedef struct {
        logic [7:0]  rd;
        logic [7:0]  rx;
        logic        err;
        int unsigned acks;
        int unsigned maxlat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_done   = 0;
    int unsigned n_pushed = 0;
    int unsigned m_acks   = 0;
    int unsigned m_lat    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] tb_beat(input logic [7:0] b, input int unsigned k);
        logic [7:0] s;
        s = b >> (6 - 2 * k);
        return s[1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  {30'd0, data}, 0);
        chk({tag, "_ctrl"},  {30'd0, ctrl}, 0);
        chk({tag, "_ack"},   {31'd0, ack}, 0);
        chk({tag, "_busy"},  {31'd0, busy}, 0);
        chk({tag, "_done"},  {31'd0, done}, 0);
        chk({tag, "_error"}, {31'd0, error}, 0);
        chk({tag, "_read_data"}, {24'd0, read_data}, 0);
        chk({tag, "_slave_rx_data"}, {24'd0, slave_rx_data}, 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && start && !busy) begin
                m_acks = 0;
                m_lat  = 0;
            end else begin
                m_lat++;
            end
            if (ack) m_acks++;
            if (error && !done) chk("error_without_done", 1, 0);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("read_data", {24'd0, read_data}, {24'd0, e.rd});
                    chk("slave_rx_data", {24'd0, slave_rx_data}, {24'd0, e.rx});
                    chk("error", {31'd0, error}, {31'd0, e.err});
                    chk("ack_count", m_acks, e.acks);
                    chk("latency_within_limit", {31'd0, m_lat > e.maxlat}, 0);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] rd, input logic [7:0] rx, input logic err,
                            input int unsigned acks, input int unsigned maxlat);
        exp_t e;
        e.rd = rd; e.rx = rx; e.err = err; e.acks = acks; e.maxlat = maxlat;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic issue_start(input logic [7:0] h, input logic [7:0] d);
        @(posedge clk); #2;
        start = 1'b1; header_in = h; data_in = d;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        chk("transaction_completed", sb.size(), 0);
        sb.delete();
    endtask

    // Full transaction; optionally checks every lane beat of a successful transfer.
    task automatic run_txn(input logic [7:0] h, input logic [7:0] d,
                           input logic [7:0] rd, input logic [7:0] rx, input logic err,
                           input int unsigned acks, input int unsigned maxlat,
                           input logic lanes, input logic [7:0] rdval);
        push_exp(rd, rx, err, acks, maxlat);
        @(posedge clk); #2;
        start = 1'b1; header_in = h; data_in = d;
        @(negedge clk);
        if (lanes) chk("idle_lanes", {28'd0, ctrl, data}, 0);
        @(posedge clk); #2;
        start = 1'b0;
        if (lanes) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("hdr_beat", {28'd0, ctrl, data}, {28'd0, 2'b01, tb_beat(h, k)});
            end
            if (h[0]) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("wdata_beat", {28'd0, ctrl, data}, {28'd0, 2'b10, tb_beat(d, k)});
                end
`ifdef FCP6_PARITY_EN
                @(negedge clk);
                chk("parity_beat", {28'd0, ctrl, data}, {28'd0, 2'b10, 1'b0, ^{h, d}});
`endif
                @(negedge clk);
                chk("wait_ack_lanes", {27'd0, ctrl, data, ack}, {27'd0, 5'b00001});
            end else begin
                @(negedge clk);
                chk("turn_lanes", {27'd0, ctrl, data, ack}, {27'd0, 5'b11001});
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("rdata_beat", {28'd0, ctrl, data}, {28'd0, 2'b10, tb_beat(rdval, k)});
                end
                @(negedge clk);
                chk("fin_lanes", {28'd0, ctrl, data}, 0);
            end
        end
        wait_drain();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; header_in = '0; data_in = '0;
        fork
            monitor();
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk_all_zero("reset");
                @(posedge clk); #2;
                rst = 1'b1;
                repeat (2) @(posedge clk);

                // Write 0xA5 to the slave, then read its register back.
                run_txn(8'h67, 8'hA5, 8'h00, 8'hA5, 1'b0, 1, WLAT, 1'b1, 8'h00);
                run_txn(8'h66, 8'h00, 8'h58, 8'hA5, 1'b0, 1, 11, 1'b1, 8'h58);

                // Address mismatch: write then read to 0x01, both time out.
                run_txn(8'h03, 8'h3C, 8'h58, 8'hA5, 1'b1, 0, 20, 1'b0, 8'h00);
                run_txn(8'h02, 8'h00, 8'h58, 8'hA5, 1'b1, 0, 20, 1'b0, 8'h00);

                // Start while busy is ignored; exactly one done expected.
                push_exp(8'h58, 8'h5A, 1'b0, 1, WLAT);
                issue_start(8'h67, 8'h5A);
                repeat (2) @(posedge clk);
                chk("busy_during_write", {31'd0, busy}, 1);
                issue_start(8'h67, 8'hFF);
                wait_drain();
                repeat (20) @(posedge clk);

                // Reset at cycle 3 of a write aborts it with no done.
                issue_start(8'h67, 8'h77);
                repeat (2) @(posedge clk); #2;
                rst = 1'b0;
                #1;
                chk_all_zero("midreset");
                repeat (2) @(posedge clk); #2;
                rst = 1'b1;
                run_txn(8'h67, 8'h11, 8'h00, 8'h11, 1'b0, 1, WLAT, 1'b1, 8'h00);
                run_txn(8'h66, 8'h00, 8'h58, 8'h11, 1'b0, 1, 11, 1'b1, 8'h58);

`ifdef FCP6_PARITY_EN
                // Corrupt the parity beat on the lane: slave must not ack.
                push_exp(8'h58, 8'h11, 1'b1, 0, 20);
                issue_start(8'h67, 8'h3C);
                repeat (8) @(posedge clk); #1;
                if (^{8'h67, 8'h3C}) force dut.w_data = 2'b00;
                else                 force dut.w_data = 2'b01;
                @(posedge clk); #1;
                release dut.w_data;
                wait_drain();
`endif
                repeat (5) @(posedge clk);
                chk("done_count", n_done, n_pushed);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join_any
    end

endmodule
